// File: rtl/console_mux_pkg.sv
// Shared types and constants for the console mux.
// Used by the TX arbiter and the RX demux.
package console_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TAG  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } arb_state_t;

  localparam logic [7:0] TAG_BASE = 8'h30;
  localparam logic [7:0] NEWLINE  = 8'h0A;

  function automatic int idle_cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first request
// above `last`, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && req[IW'((int'(last) + k) % N)]) begin
        any = 1'b1;
        gnt[IW'((int'(last) + k) % N)] = 1'b1;
        idx = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin share of one uart_tx
// between N_CH console sources, optional channel tag.
module uart_tx_arbiter
  import console_mux_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int TAG_EN       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*8-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [N_CH-1:0]   grant,
  output logic              busy
);

  localparam int IW = $clog2(N_CH);
  localparam int CW = idle_cnt_w(IDLE_TIMEOUT);
  localparam logic [CW-1:0] TO = CW'(IDLE_TIMEOUT);

  arb_state_t      r_state;
  logic [N_CH-1:0] r_grant;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_is_nl;
  logic            r_done_q;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;

  logic [N_CH-1:0] w_pgnt;
  logic [IW-1:0]   w_pidx;
  logic            w_pany;
  logic [IW+2:0]   w_sel;
  logic [7:0]      w_byte;
  logic            w_hold;
  logic            w_xfer;
  logic            w_rise;

  rr_pick #(
    .N  (N_CH),
    .IW (IW)
  ) u_pick (
    .req  (in_valid),
    .last (r_last),
    .gnt  (w_pgnt),
    .idx  (w_pidx),
    .any  (w_pany)
  );

  assign w_sel  = {r_idx, 3'b000};
  assign w_byte = in_data[w_sel +: 8];
  assign w_hold = (r_state == S_HOLD);
  assign w_xfer = w_hold && in_valid[r_idx];
  // done_q resets high so a done already high never counts
  assign w_rise = tx_done && !r_done_q;

  assign in_ready = w_hold ? r_grant : '0;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign grant    = r_grant;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_last     <= IW'(N_CH - 1);
      r_cnt      <= '0;
      r_is_nl    <= 1'b0;
      r_done_q   <= 1'b1;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_done_q   <= tx_done;
      r_tx_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_pany) begin
            r_grant <= w_pgnt;
            r_idx   <= w_pidx;
            r_cnt   <= '0;
            r_state <= (TAG_EN != 0) ? S_TAG : S_HOLD;
          end
        end
        S_TAG: begin
          r_tx_data  <= TAG_BASE + 8'(r_idx);
          r_tx_start <= 1'b1;
          r_is_nl    <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_HOLD: begin
          if (w_xfer) begin
            r_tx_data  <= w_byte;
            r_is_nl    <= (w_byte == NEWLINE);
            r_tx_start <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end else if (r_cnt == TO) begin
            r_last  <= r_idx;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (w_rise) begin
            if (r_is_nl) begin
              r_last  <= r_idx;
              r_grant <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (tagged and untagged),
// each driving a uart_tx stub.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*8-1:0] in_data  [2];
  logic [N-1:0]   in_valid [2];
  logic [N-1:0]   in_ready [2];
  logic [N-1:0]   grant    [2];
  logic [7:0]     tx_data  [2];
  logic           tx_start [2];
  logic           tx_done  [2] = '{1'b1, 1'b1};
  logic           busy     [2];
  int             scnt     [2] = '{0, 0};

  logic [7:0] srcq [8][$];
  logic [7:0] tlog [2][$];
  logic [N-1:0] glog [2][$];
  int scyc [2][$];
  int gaps [$];
  int cyc = 0;
  int rise_cyc [2] = '{0, 0};
  int rises [2] = '{0, 0};
  int starts [2] = '{0, 0};
  bit outst [2] = '{1'b0, 1'b0};
  logic done_p [2] = '{1'b1, 1'b1};
  int bad_rdy = 0;
  int n_tests = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .N_CH(N), .IDLE_TIMEOUT(TO), .TAG_EN(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx_data(tx_data[0]),
    .tx_start(tx_start[0]), .tx_done(tx_done[0]),
    .grant(grant[0]), .busy(busy[0])
  );

  uart_tx_arbiter #(
    .N_CH(N), .IDLE_TIMEOUT(TO), .TAG_EN(0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx_data(tx_data[1]),
    .tx_start(tx_start[1]), .tx_done(tx_done[1]),
    .grant(grant[1]), .busy(busy[1])
  );

  // uart_tx stub: done falls 1 cycle after start, rises 20 later
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (tx_start[k]) begin
        tx_done[k] <= 1'b0;
        scnt[k] <= 20;
      end else if (scnt[k] != 0) begin
        scnt[k] <= scnt[k] - 1;
        if (scnt[k] == 1) tx_done[k] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        outst[k] = 1'b0;
      end else begin
        if (in_ready[k] != 0 &&
            (outst[k] || tx_start[k] ||
             (in_ready[k] & ~grant[k]) != 0))
          bad_rdy++;
        if (tx_done[k] && !done_p[k]) begin
          rises[k]++;
          rise_cyc[k] = cyc;
          outst[k] = 1'b0;
        end
        if (tx_start[k]) begin
          tlog[k].push_back(tx_data[k]);
          glog[k].push_back(grant[k]);
          scyc[k].push_back(cyc);
          starts[k]++;
          outst[k] = 1'b1;
          if (k == 1) gaps.push_back(cyc - rise_cyc[1]);
        end
      end
      done_p[k] = tx_done[k];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic void drive_src();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[k][i] = (srcq[k*N+i].size() != 0);
        in_data[k][8*i +: 8] =
          in_valid[k][i] ? srcq[k*N+i][0] : 8'h00;
      end
    end
  endfunction

  task automatic tick();
    logic [N-1:0] f [2];
    @(posedge clk);
    for (int k = 0; k < 2; k++) f[k] = in_valid[k] & in_ready[k];
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        if (f[k][i]) void'(srcq[k*N+i].pop_front());
    drive_src();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int k, input int ch, input string s);
    for (int j = 0; j < s.len(); j++) srcq[k*N+ch].push_back(s[j]);
  endtask

  function automatic bit pending(input int k);
    for (int i = 0; i < N; i++)
      if (srcq[k*N+i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_quiet(input int k, input int budget,
                            input string tag);
    int n = 0;
    while ((busy[k] || pending(k) || !tx_done[k]) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, n, 0);
  endtask

  function automatic logic [31:0] getb(input int k, input int i);
    return (i < tlog[k].size()) ? 32'(tlog[k][i]) : 32'hdead;
  endfunction

  task automatic check_log(input int k, input int b,
                           input string tag,
                           input logic [7:0] e [$]);
    check({tag, "_len"}, tlog[k].size() - b, e.size());
    foreach (e[j])
      check($sformatf("%s_b%0d", tag, j), getb(k, b + j), 32'(e[j]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) srcq[i].delete();
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int b, n, r, t, g, sb, st;
    drive_src();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_grant", grant[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_start", tx_start[0], 0);
    check("rst_data", tx_data[0], 0);
    check("rst_ready", in_ready[0], 0);
    rst_n = 1'b1;
    tick();

    // ch2 "hi\n" with tag
    b = tlog[0].size();
    push(0, 2, "hi\n");
    wait_quiet(0, 400, "t1");
    check_log(0, b, "t1", '{8'h32, 8'h68, 8'h69, 8'h0A});
    for (int j = 0; j < 4; j++)
      check($sformatf("t1_gnt%0d", j),
            (b + j < glog[0].size()) ? 32'(glog[0][b+j]) : 32'hdead,
            32'h4);
    check("t1_gnt_end", grant[0], 0);

    // ch0 and ch1 lines pending from reset
    do_reset();
    b = tlog[0].size();
    push(0, 0, "a\n");
    push(0, 1, "b\n");
    wait_quiet(0, 600, "t2");
    check_log(0, b, "t2",
      '{8'h30, 8'h61, 8'h0A, 8'h31, 8'h62, 8'h0A});

    // ch3 goes quiet, ch1 waits: idle timeout
    b = tlog[0].size();
    push(0, 3, "x");
    n = 0;
    while (grant[0] != 4'b1000 && n < 10) begin tick(); n++; end
    check("t3_gnt3", grant[0], 4'b1000);
    push(0, 1, "y\n");
    r = rises[0];
    n = 0;
    while (rises[0] < r + 2 && n < 100) begin tick(); n++; end
    check("t3_rises", rises[0] - r, 2);
    n = 0;
    while (grant[0] == 4'b1000 && n < 100) begin tick(); n++; end
    check("t3_hold_cyc", n, 52);
    check("t3_rel", grant[0], 0);
    tick();
    check("t3_gnt1", grant[0], 4'b0010);
    wait_quiet(0, 600, "t3");
    check_log(0, b, "t3",
      '{8'h33, 8'h78, 8'h31, 8'h79, 8'h0A});

    // untagged back-to-back stream on ch1
    b = tlog[1].size();
    sb = scyc[1].size();
    g = gaps.size();
    push(1, 1, "pqr");
    n = 0;
    while (in_valid[1] == 0 && n < 5) begin tick(); n++; end
    t = cyc;
    wait_quiet(1, 600, "t4");
    check_log(1, b, "t4", '{8'h70, 8'h71, 8'h72});
    check("t4_first",
          (sb < scyc[1].size()) ? scyc[1][sb] - t : -1, 2);
    check("t4_gap1", (g + 1 < gaps.size()) ? gaps[g+1] : -1, 2);
    check("t4_gap2", (g + 2 < gaps.size()) ? gaps[g+2] : -1, 2);
    check("t4_gnt",
          (b < glog[1].size()) ? 32'(glog[1][b]) : 32'hdead,
          32'h2);

    // ch0 repeats lines while ch2 waits
    do_reset();
    b = tlog[0].size();
    push(0, 0, "a\na\n");
    push(0, 2, "c\n");
    wait_quiet(0, 900, "t5");
    check_log(0, b, "t5",
      '{8'h30, 8'h61, 8'h0A, 8'h32, 8'h63, 8'h0A,
        8'h30, 8'h61, 8'h0A});

    // reset in WAIT mid-byte
    st = starts[0];
    push(0, 2, "zz\n");
    n = 0;
    while (starts[0] < st + 2 && n < 100) begin tick(); n++; end
    repeat (5) tick();
    check("t6_pre_busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("t6_data", tx_data[0], 0);
    check("t6_start", tx_start[0], 0);
    check("t6_grant", grant[0], 0);
    check("t6_ready", in_ready[0], 0);
    check("t6_busy", busy[0], 0);
    for (int i = 0; i < 8; i++) srcq[i].delete();
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    st = starts[0];
    n = 0;
    while (!tx_done[0] && n < 40) begin tick(); n++; end
    repeat (3) tick();
    check("t6_no_start", starts[0] - st, 0);
    b = tlog[0].size();
    push(0, 0, "k\n");
    n = 0;
    while (grant[0] == 0 && n < 10) begin tick(); n++; end
    check("t6_gnt0", grant[0], 4'b0001);
    wait_quiet(0, 400, "t6");
    check_log(0, b, "t6", '{8'h30, 8'h6B, 8'h0A});

    check("ready_outside_hold", bad_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
